// File: rtl/sf2_usram_sim.sv
// Purpose : micro-SRAM simulation model, one sync write port + READ_PORTS read ports, self-clearing after reset.
// Latency : read address to R_DOUT = ADDR_REG + DOUT_REG clock edges (0/0 is purely combinational).
// Backpr. : none; writes ignored while BUSY (array clearing), out-of-range writes dropped, out-of-range reads return 0.
//
// Ports:
//   CLK, ARST_N                  - single clock, asynchronous active-low reset
//   BUSY                         - high while the init sequencer clears the array
//   C_EN, C_WEN, C_ADDR, C_DIN   - write port (write needs C_EN & C_WEN)
//   R_EN, R_ADDR, R_ADDR_SRST_N  - per-port address register load / address / sync clear
//   R_DOUT_EN, R_DOUT_SRST_N     - per-port output register load / sync clear
//   R_DOUT                       - per-port read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
module sf2_usram_sim #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int READ_PORTS = 2,
    parameter int ADDR_REG   = 1,
    parameter int DOUT_REG   = 1
) (
    (* clkbuf_sink *)
    input  logic                             CLK,
    input  logic                             ARST_N,
    output logic                             BUSY,
    input  logic                             C_EN,
    input  logic                             C_WEN,
    input  logic [ADDR_WIDTH-1:0]            C_ADDR,
    input  logic [DATA_WIDTH-1:0]            C_DIN,
    input  logic [READ_PORTS-1:0]            R_EN,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] R_ADDR,
    input  logic [READ_PORTS-1:0]            R_ADDR_SRST_N,
    input  logic [READ_PORTS-1:0]            R_DOUT_EN,
    input  logic [READ_PORTS-1:0]            R_DOUT_SRST_N,
    output logic [READ_PORTS*DATA_WIDTH-1:0] R_DOUT
);

    // One extra bit so the range compare never degenerates when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_eff_addr [READ_PORTS];
    logic [DATA_WIDTH-1:0] w_arr      [READ_PORTS];
    logic [DATA_WIDTH-1:0] w_dout     [READ_PORTS];

    logic w_wr_ok;

    // ------------------------------------------------------------------
    // Init sequencer: walks every word once, then parks in READY.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt    = ST_READY;
                    w_init_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_READY;
                w_init_cnt_nxt = '0;
            end
        endcase
    end

    assign BUSY = (r_state == ST_INIT);

    // ------------------------------------------------------------------
    // Array write. The array itself has no reset; the sequencer owns the
    // write port while BUSY, so user writes in that window are lost.
    // ------------------------------------------------------------------
    assign w_wr_ok = (r_state == ST_READY) && C_EN && C_WEN && ({1'b0, C_ADDR} < DEPTH_X);

    always_ff @(posedge CLK) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[C_ADDR] <= C_DIN;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_port
        logic w_rd_ok;

        if (ADDR_REG != 0) begin : g_areg
            logic [ADDR_WIDTH-1:0] r_addr;
            always_ff @(posedge CLK or negedge ARST_N) begin
                if (!ARST_N) begin
                    r_addr <= '0;
                end else if (!R_ADDR_SRST_N[gi]) begin
                    r_addr <= '0;
                end else if (R_EN[gi]) begin
                    r_addr <= R_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            assign w_eff_addr[gi] = r_addr;
        end else begin : g_acomb
            logic w_unused;
            assign w_unused       = &{1'b0, R_EN[gi], R_ADDR_SRST_N[gi]};
            assign w_eff_addr[gi] = R_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end

        // Registered address + combinational array read gives write-first
        // behaviour on a same-edge collision.
        assign w_rd_ok   = (r_state == ST_READY) && ({1'b0, w_eff_addr[gi]} < DEPTH_X);
        assign w_arr[gi] = w_rd_ok ? r_mem[w_eff_addr[gi]] : '0;

        if (DOUT_REG != 0) begin : g_dreg
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge CLK or negedge ARST_N) begin
                if (!ARST_N) begin
                    r_dout <= '0;
                end else if (!R_DOUT_SRST_N[gi]) begin
                    r_dout <= '0;
                end else if (R_DOUT_EN[gi]) begin
                    r_dout <= w_arr[gi];
                end
            end
            assign w_dout[gi] = r_dout;
        end else begin : g_dcomb
            logic w_unused;
            assign w_unused   = &{1'b0, R_DOUT_EN[gi], R_DOUT_SRST_N[gi]};
            assign w_dout[gi] = w_arr[gi];
        end
    end

    always_comb begin
        R_DOUT = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            R_DOUT[i*DATA_WIDTH +: DATA_WIDTH] = w_dout[i];
        end
    end

endmodule

// File: tb/tb_sf2_usram_sim.sv
// Directed bench for sf2_usram_sim. Four instances share one stimulus:
//   u_a defaults (ADDR_REG=1, DOUT_REG=1, DEPTH=64)
//   u_b ADDR_REG=0, DOUT_REG=0 (combinational read)
//   u_c DEPTH=48 (out-of-range handling)
//   u_d ADDR_REG=0, DOUT_REG=1 (read-old collision behaviour)
module tb_sf2_usram_sim;

    localparam int DW = 18;
    localparam int AW = 6;
    localparam int RP = 2;

    logic           clk;
    logic           arst_n;
    logic           c_en;
    logic           c_wen;
    logic [AW-1:0]  c_addr;
    logic [DW-1:0]  c_din;
    logic [RP-1:0]  r_en;
    logic [RP*AW-1:0] r_addr;
    logic [RP-1:0]  r_addr_srst_n;
    logic [RP-1:0]  r_dout_en;
    logic [RP-1:0]  r_dout_srst_n;

    logic             busy_a, busy_b, busy_c, busy_d;
    logic [RP*DW-1:0] dout_a, dout_b, dout_c, dout_d;

    int checks = 0;
    int errors = 0;

    sf2_usram_sim u_a (
        .CLK(clk), .ARST_N(arst_n), .BUSY(busy_a),
        .C_EN(c_en), .C_WEN(c_wen), .C_ADDR(c_addr), .C_DIN(c_din),
        .R_EN(r_en), .R_ADDR(r_addr), .R_ADDR_SRST_N(r_addr_srst_n),
        .R_DOUT_EN(r_dout_en), .R_DOUT_SRST_N(r_dout_srst_n), .R_DOUT(dout_a)
    );

    sf2_usram_sim #(.ADDR_REG(0), .DOUT_REG(0)) u_b (
        .CLK(clk), .ARST_N(arst_n), .BUSY(busy_b),
        .C_EN(c_en), .C_WEN(c_wen), .C_ADDR(c_addr), .C_DIN(c_din),
        .R_EN(r_en), .R_ADDR(r_addr), .R_ADDR_SRST_N(r_addr_srst_n),
        .R_DOUT_EN(r_dout_en), .R_DOUT_SRST_N(r_dout_srst_n), .R_DOUT(dout_b)
    );

    sf2_usram_sim #(.DEPTH(48)) u_c (
        .CLK(clk), .ARST_N(arst_n), .BUSY(busy_c),
        .C_EN(c_en), .C_WEN(c_wen), .C_ADDR(c_addr), .C_DIN(c_din),
        .R_EN(r_en), .R_ADDR(r_addr), .R_ADDR_SRST_N(r_addr_srst_n),
        .R_DOUT_EN(r_dout_en), .R_DOUT_SRST_N(r_dout_srst_n), .R_DOUT(dout_c)
    );

    sf2_usram_sim #(.ADDR_REG(0), .DOUT_REG(1)) u_d (
        .CLK(clk), .ARST_N(arst_n), .BUSY(busy_d),
        .C_EN(c_en), .C_WEN(c_wen), .C_ADDR(c_addr), .C_DIN(c_din),
        .R_EN(r_en), .R_ADDR(r_addr), .R_ADDR_SRST_N(r_addr_srst_n),
        .R_DOUT_EN(r_dout_en), .R_DOUT_SRST_N(r_dout_srst_n), .R_DOUT(dout_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        c_en   = 1'b1;
        c_wen  = 1'b1;
        c_addr = addr;
        c_din  = data;
        tick();
        c_en   = 1'b0;
        c_wen  = 1'b0;
    endtask

    initial begin
        arst_n        = 1'b0;
        c_en          = 1'b0;
        c_wen         = 1'b0;
        c_addr        = '0;
        c_din         = '0;
        r_en          = 2'b11;
        r_addr        = {6'd63, 6'd5};
        r_addr_srst_n = 2'b11;
        r_dout_en     = 2'b11;
        r_dout_srst_n = 2'b11;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy_a", 36'(busy_a), 36'd1);
        check("rst_busy_c", 36'(busy_c), 36'd1);
        check("rst_dout_a", 36'(dout_a), 36'd0);
        check("rst_dout_d", 36'(dout_d), 36'd0);

        // ---------------- init sequence ----------------
        // Write to address 5 during INIT must be ignored.
        arst_n = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            if (n == 3) begin
                c_en = 1'b1; c_wen = 1'b1; c_addr = 6'd5; c_din = 18'h3FFFF;
            end
            if (n == 4) begin
                c_en = 1'b0; c_wen = 1'b0;
            end
            tick();
            check("init_busy_a", 36'(busy_a), 36'(n < 64));
            check("init_busy_c", 36'(busy_c), 36'(n < 48));
        end

        check("init_rd5_b", 36'(dout_b[17:0]), 36'd0);
        check("init_rd63_b", 36'(dout_b[35:18]), 36'd0);
        tick();
        tick();
        check("init_rd5_a", 36'(dout_a[17:0]), 36'd0);
        check("init_rd63_a", 36'(dout_a[35:18]), 36'd0);

        // ---------------- write/read latency ----------------
        do_write(6'd0, 18'h00555);
        do_write(6'd10, 18'h12345);
        r_addr = {6'd63, 6'd10};
        #1;
        check("lat0_b", 36'(dout_b[17:0]), 36'h12345);
        tick();
        check("lat1_a", 36'(dout_a[17:0]), 36'h00000);
        check("lat1_d", 36'(dout_d[17:0]), 36'h12345);
        tick();
        check("lat2_a", 36'(dout_a[17:0]), 36'h12345);

        // ---------------- collision ----------------
        r_addr = {6'd3, 6'd3};
        c_en = 1'b1; c_wen = 1'b1; c_addr = 6'd3; c_din = 18'h00AAA;
        tick();
        c_en = 1'b0; c_wen = 1'b0;
        check("col_b_p0", 36'(dout_b[17:0]), 36'h00AAA);
        check("col_b_p1", 36'(dout_b[35:18]), 36'h00AAA);
        check("col_d_old", 36'(dout_d[17:0]), 36'h00000);
        tick();
        check("col_a_p0", 36'(dout_a[17:0]), 36'h00AAA);
        check("col_a_p1", 36'(dout_a[35:18]), 36'h00AAA);
        check("col_d_new", 36'(dout_d[17:0]), 36'h00AAA);

        // ---------------- enables and sync clears ----------------
        r_dout_en = 2'b01;
        r_addr    = {6'd10, 6'd3};
        tick();
        tick();
        check("hold_p1", 36'(dout_a[35:18]), 36'h00AAA);
        check("hold_p0", 36'(dout_a[17:0]), 36'h00AAA);
        r_dout_srst_n = 2'b01;
        r_dout_en     = 2'b11;
        tick();
        check("dsrst_p1", 36'(dout_a[35:18]), 36'h00000);
        r_dout_srst_n = 2'b11;
        tick();
        check("dsrst_rel_p1", 36'(dout_a[35:18]), 36'h12345);
        r_addr_srst_n = 2'b10;
        r_addr        = {6'd10, 6'd10};
        tick();
        r_addr_srst_n = 2'b11;
        r_en          = 2'b10;
        tick();
        check("asrst_p0", 36'(dout_a[17:0]), 36'h00555);
        r_en = 2'b11;

        // ---------------- out of range (DEPTH=48) ----------------
        do_write(6'd50, 18'h1BEEF);
        do_write(6'd47, 18'h2CAFE);
        r_addr = {6'd47, 6'd50};
        tick();
        tick();
        check("oor_c_50", 36'(dout_c[17:0]), 36'h00000);
        check("oor_c_47", 36'(dout_c[35:18]), 36'h2CAFE);
        check("oor_a_50", 36'(dout_a[17:0]), 36'h1BEEF);

        // ---------------- reset mid-operation ----------------
        arst_n = 1'b0;
        #1;
        check("mrst_dout_a", 36'(dout_a), 36'd0);
        check("mrst_dout_d", 36'(dout_d), 36'd0);
        check("mrst_busy_a", 36'(busy_a), 36'd1);
        tick();
        arst_n = 1'b1;
        repeat (20) tick();
        arst_n = 1'b0;
        #1;
        check("mrst20_busy_a", 36'(busy_a), 36'd1);
        tick();
        arst_n = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            tick();
            check("reinit_busy_a", 36'(busy_a), 36'(n < 64));
        end
        r_addr = {6'd50, 6'd10};
        tick();
        tick();
        check("reinit_rd10", 36'(dout_a[17:0]), 36'd0);
        check("reinit_rd50", 36'(dout_a[35:18]), 36'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sf2_usram_sim.md
Name: sf2_usram_sim

Overview:
- Behavioural simulation model of a parametrised micro-SRAM: one synchronous write port and READ_PORTS independent read ports.
- Each read port has an optional address register and an optional output register.
- After reset, a hardware init sequencer clears the array and holds BUSY high until clearing completes.
- Sits with the SF2 cell simulation models as the generalised successor of the fixed 64x18 two-read/one-write RAM. All ports share one clock.

Parameters:
- DATA_WIDTH, 18, word width in bits.
- ADDR_WIDTH, 6, address width in bits.
- DEPTH, 64, number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_PORTS, 2, number of read ports (>= 1).
- ADDR_REG, 1, 1 = read address registered; 0 = read address used combinationally.
- DOUT_REG, 1, 1 = read data registered; 0 = read data combinational.

Ports:
- CLK  input  1  single clock for all ports; clkbuf_sink.
- ARST_N  input  1  asynchronous reset, active-low.
- BUSY  output  1  high while the init sequencer is clearing the array.
- C_EN  input  1  write port enable.
- C_WEN  input  1  write strobe; a write needs C_EN & C_WEN.
- C_ADDR  input  ADDR_WIDTH  write address.
- C_DIN  input  DATA_WIDTH  write data.
- R_EN  input  READ_PORTS  per-port address-register load enable.
- R_ADDR  input  READ_PORTS*ADDR_WIDTH  per-port read address; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- R_ADDR_SRST_N  input  READ_PORTS  per-port synchronous clear of the address register, active-low.
- R_DOUT_EN  input  READ_PORTS  per-port output-register load enable.
- R_DOUT_SRST_N  input  READ_PORTS  per-port synchronous clear of the output register, active-low.
- R_DOUT  output  READ_PORTS*DATA_WIDTH  per-port read data, sliced like R_ADDR.

Behaviour:
- Reset (ARST_N low, asynchronous):
  - All address registers = 0, all output registers = 0, so R_DOUT = 0 when DOUT_REG = 1.
  - Init counter = 0, state = INIT, BUSY = 1.
  - Array contents are not guaranteed during reset.
- State INIT:
  - Each posedge writes mem[cnt] <= 0 and increments cnt.
  - On the edge that clears address DEPTH-1, state goes to READY and BUSY falls after that edge. INIT therefore lasts exactly DEPTH cycles after reset release.
  - C_EN/C_WEN are ignored in INIT.
  - Array read value is forced to 0 for every port in INIT.
- State READY:
  - Stays in READY until the next ARST_N assertion.
  - ARST_N asserted mid-INIT restarts the sequence from cnt = 0.
- Write: in READY, at a posedge with C_EN & C_WEN and C_ADDR < DEPTH, mem[C_ADDR] <= C_DIN. Writes with C_ADDR >= DEPTH are dropped silently.
- Address stage, per port, when ADDR_REG = 1:
  - At posedge, R_ADDR_SRST_N low loads 0 (priority over enable).
  - Otherwise R_EN high loads R_ADDR; otherwise the register holds.
  - When ADDR_REG = 0, the effective address is R_ADDR directly.
- Array read: arr_i = mem[eff_addr_i], combinational from the effective address. Returns 0 when eff_addr_i >= DEPTH or in INIT.
- Output stage, per port, when DOUT_REG = 1:
  - At posedge, R_DOUT_SRST_N low loads 0 (priority).
  - Otherwise R_DOUT_EN high loads arr_i; otherwise the register holds.
  - When DOUT_REG = 0, R_DOUT slice = arr_i.
- Latency from R_ADDR to R_DOUT is ADDR_REG + DOUT_REG clock edges. With 0/0 the path is purely combinational.
- Write/read collision (same address, same edge):
  - ADDR_REG = 1: after the edge, arr_i shows the new data (write-first).
  - DOUT_REG = 1 with ADDR_REG = 0: the output register captures the old data on that edge and the new data on the following edge.
- All read ports are independent. Any number may read the same address, including the address being written.
- Enables and synchronous clears are not gated by BUSY. The registers operate normally and capture 0 data during INIT.

Test Plan:
- Init and BUSY: release ARST_N with DEPTH = 64. BUSY stays 1 for exactly 64 posedges, then 0. A read of any address afterwards returns 0; a write attempted during INIT to address 5 with 18'h3FFFF reads back 0.
- Write/read latency: defaults; write 18'h12345 to address 10. Present R_ADDR[0] = 10 with R_EN = 1 and R_DOUT_EN = 1. R_DOUT[0] = 18'h12345 exactly 2 edges later. Repeat with ADDR_REG = 0, DOUT_REG = 0: value appears in the same cycle.
- Dual-port and collision: write 18'h00AAA to address 3 on the same edge that port 0 and port 1 both register address 3. Both ports read 18'h00AAA (write-first) one edge later.
- Enables and sync clears: with port-1 R_DOUT_EN = 0, changing the address leaves R_DOUT[1] unchanged. Pulsing R_DOUT_SRST_N[1] low with R_DOUT_EN = 1 gives R_DOUT[1] = 0. Pulsing R_ADDR_SRST_N[0] low reads address 0.
- Out of range: DEPTH = 48, ADDR_WIDTH = 6. A write to address 50 is dropped and a read of address 50 returns 0; a write/read at address 47 works normally.
- Reset mid-operation: assert ARST_N at INIT count 20 and again in READY after writes. R_DOUT goes to 0 immediately, BUSY goes to 1, and INIT re-runs the full 64 cycles, after which previously written data reads back as 0.
